serial_add_ctrl: RTL

//   Sequences a single 1-bit full-adder cell (carry = majority(A,B,C), sum = A^B^C)
//   to add or subtract two WIDTH-bit operands bit-serially, LSB first, one bit per clock.

---
 rtl/serial_add_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add/subtract sequencer around one shared
// full-adder cell. Operands are latched on an accepted start and consumed
// LSB first, one bit per clock. The result is assembled MSB-down in the sum
// register.
//
// Ports:
//   clk, n_reset    rising-edge clock, synchronous active-low reset
//   start, sub      request and operation select (0: a+b, 1: a-b), sampled in IDLE
//   a, b            WIDTH-bit operands, sampled with start
//   ready/busy/done one-hot state flags (IDLE / RUN / DONE)
//   sum, cout, ovf  result, final carry and signed overflow; valid from done,
//                   held until the next accepted start
`timescale 1ns/1ps

module serial_add_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, cout_q, ovf_q;
  logic             ready_q, busy_q, done_q;
  logic             fa_sum, carry_d;

  serial_add_fa u_fa (
    .a_i (a_sh_q[0]),
    .b_i (b_sh_q[0]),
    .c_i (carry_q),
    .s_o (fa_sum),
    .c_o (carry_d)
  );

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
            a_sh_q  <= a;
            b_sh_q  <= b ^ {WIDTH{sub}};
            carry_q <= sub;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            state_q <= S_RUN;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        S_RUN: begin
          carry_q <= carry_d;
          sum_q   <= {fa_sum, sum_q[WIDTH-1:1]};
          a_sh_q  <= a_sh_q >> 1;
          b_sh_q  <= b_sh_q >> 1;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            // carry_q is the carry into the MSB on this bit; carry_d is the
            // carry out. Registering both now makes them valid with done.
            cout_q  <= carry_d;
            ovf_q   <= carry_q ^ carry_d;
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign cout  = cout_q;
  assign ovf   = ovf_q;

endmodule
